// File: rtl/adc_sample_scheduler.sv
// Periodic conversion scheduler for a group of AD7357 drivers.
// Ports: i_clk, i_rst (async, active-high), i_period/i_burst_len
// (captured on i_arm), i_arm/i_stop pulses, i_drv_ready per driver.
// Outputs: o_drv_start (broadcast start pulse), o_tick, o_busy, o_done,
// and the saturating o_miss_count.
module adc_sample_scheduler #(
  parameter int PERIOD_WIDTH = 16,
  parameter int BURST_WIDTH  = 16,
  parameter int MISS_WIDTH   = 8,
  parameter int NUM_DRIVERS  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  input  logic [BURST_WIDTH-1:0]  i_burst_len,
  input  logic                    i_arm,
  input  logic                    i_stop,
  input  logic [NUM_DRIVERS-1:0]  i_drv_ready,
  output logic                    o_drv_start,
  output logic                    o_tick,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [MISS_WIDTH-1:0]   o_miss_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam logic [PERIOD_WIDTH-1:0] CNT_ONE   = 1;
  localparam logic [BURST_WIDTH-1:0]  BURST_ONE = 1;
  localparam logic [MISS_WIDTH-1:0]   MISS_ONE  = 1;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PERIOD_WIDTH-1:0] r_period;
  logic [PERIOD_WIDTH-1:0] w_period_nxt;
  logic [PERIOD_WIDTH-1:0] r_cnt;
  logic [PERIOD_WIDTH-1:0] w_cnt_nxt;
  logic [BURST_WIDTH-1:0]  r_burst;
  logic [BURST_WIDTH-1:0]  w_burst_nxt;
  logic [BURST_WIDTH-1:0]  r_issued;
  logic [BURST_WIDTH-1:0]  w_issued_nxt;
  logic [MISS_WIDTH-1:0]   r_miss;
  logic [MISS_WIDTH-1:0]   w_miss_nxt;
  logic                    r_start;
  logic                    w_start_nxt;
  logic                    r_start_d;
  logic                    r_tick;
  logic                    w_tick_nxt;
  logic                    r_busy;
  logic                    r_done;
  logic                    w_done_nxt;

  logic w_tick;
  logic w_all_rdy;
  logic w_accept;
  logic w_last;
  logic w_drain_exit;

  assign w_tick    = (r_state == S_RUN) && (r_cnt == '0);
  assign w_all_rdy = &i_drv_ready;

  // A start being issued this cycle has not yet pulled ready low, so a
  // tick landing on it (period 0) must not count as accepted.
  assign w_accept = w_tick && !i_stop && w_all_rdy && !r_start;
  assign w_last   = (r_burst != '0) &&
                    (r_issued == (r_burst - BURST_ONE));

  // Two start-free cycles ensure the driver has left IDLE and come back.
  assign w_drain_exit = w_all_rdy && !r_start && !r_start_d;

  always_comb begin
    w_state_nxt  = r_state;
    w_period_nxt = r_period;
    w_burst_nxt  = r_burst;
    w_cnt_nxt    = r_cnt;
    w_issued_nxt = r_issued;
    w_miss_nxt   = r_miss;
    w_start_nxt  = 1'b0;
    w_tick_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_arm) begin
          w_period_nxt = i_period;
          w_burst_nxt  = i_burst_len;
          w_cnt_nxt    = '0;
          w_issued_nxt = '0;
          w_miss_nxt   = '0;
          w_state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == r_period) begin
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
        if (i_stop) begin
          w_state_nxt = S_DRAIN;
        end else if (w_tick) begin
          w_tick_nxt = 1'b1;
          if (w_accept) begin
            w_start_nxt  = 1'b1;
            w_issued_nxt = r_issued + BURST_ONE;
            if (w_last) begin
              w_state_nxt = S_DRAIN;
            end
          end else if (r_miss != '1) begin
            w_miss_nxt = r_miss + MISS_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (w_drain_exit) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_period  <= '0;
      r_burst   <= '0;
      r_cnt     <= '0;
      r_issued  <= '0;
      r_miss    <= '0;
      r_start   <= 1'b0;
      r_start_d <= 1'b0;
      r_tick    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_period  <= w_period_nxt;
      r_burst   <= w_burst_nxt;
      r_cnt     <= w_cnt_nxt;
      r_issued  <= w_issued_nxt;
      r_miss    <= w_miss_nxt;
      r_start   <= w_start_nxt;
      r_start_d <= r_start;
      r_tick    <= w_tick_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= w_done_nxt;
    end
  end

  assign o_drv_start  = r_start;
  assign o_tick       = r_tick;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_miss_count = r_miss;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler with two modelled 14-bit drivers.
// Cycle-level event lists are predicted from tick/ready arithmetic.
module tb_adc_sample_scheduler;
  localparam int PW = 16;
  localparam int BW = 16;
  localparam int MW = 8;
  localparam int ND = 2;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [PW-1:0] i_period = '0;
  logic [BW-1:0] i_burst_len = '0;
  logic          i_arm = 1'b0;
  logic          i_stop = 1'b0;
  logic [ND-1:0] i_drv_ready;
  logic          o_drv_start;
  logic          o_tick;
  logic          o_busy;
  logic          o_done;
  logic [MW-1:0] o_miss_count;

  logic [ND-1:0] hold_mask = '0;
  logic [4:0]    drv_busy;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  int e_tick[$];
  int e_start[$];
  int e_done;
  int e_miss;

  adc_sample_scheduler #(
    .PERIOD_WIDTH(PW),
    .BURST_WIDTH (BW),
    .MISS_WIDTH  (MW),
    .NUM_DRIVERS (ND)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_period    (i_period),
    .i_burst_len (i_burst_len),
    .i_arm       (i_arm),
    .i_stop      (i_stop),
    .i_drv_ready (i_drv_ready),
    .o_drv_start (o_drv_start),
    .o_tick      (o_tick),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_miss_count(o_miss_count)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Driver: a start in cycle s drops ready for s+1..s+17.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) drv_busy <= 5'd0;
    else if (o_drv_start) drv_busy <= 5'd17;
    else if (drv_busy != 5'd0) drv_busy <= drv_busy - 5'd1;
  end

  assign i_drv_ready = ~hold_mask & {ND{drv_busy == 5'd0}};

  // Expected events for an arm in cycle a; s is the stop cycle or -1.
  task automatic model_run(input int a, input int p, input int b,
                           input int s);
    int last_s;
    int acc;
    int d;
    int c;
    e_tick.delete();
    e_start.delete();
    e_miss = 0;
    last_s = -1000;
    acc = 0;
    d = -1;
    for (int t = a + 1; t < a + 100000 && d < 0; t++) begin
      if (s >= 0 && t == s) begin
        d = t + 1;
      end else if ((t - a - 1) % (p + 1) == 0) begin
        e_tick.push_back(t + 1);
        if (t - last_s >= 18) begin
          e_start.push_back(t + 1);
          last_s = t + 1;
          acc++;
          if (b != 0 && acc == b) d = t + 1;
        end else if (e_miss < 255) begin
          e_miss++;
        end
      end
    end
    c = d;
    while (c - last_s < 18) c++;
    e_done = c + 1;
  endtask

  task automatic run_case(input int p, input int b, input int stop_after,
                          input bit arm_mid, output int a,
                          output int n_start, output int n_tick,
                          output int first_s, output int last_s);
    int q_tick[$];
    int q_start[$];
    int done_c;
    int s;
    int n;
    bit got;
    bit ok;
    @(posedge i_clk); #1;
    i_period = PW'(p);
    i_burst_len = BW'(b);
    i_arm = 1'b1;
    a = cyc;
    s = (stop_after > 0) ? a + stop_after : -1;
    got = 1'b0;
    n = 0;
    done_c = -1;
    while (!got && n < 4000) begin
      @(posedge i_clk); #1;
      n++;
      i_arm = arm_mid && (cyc == a + 10);
      i_stop = (cyc == s);
      if (cyc == a + 1) begin
        checks++;
        if (o_busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_after_arm: got %b want 1", o_busy);
        end
      end
      if (o_tick) q_tick.push_back(cyc);
      if (o_drv_start) q_start.push_back(cyc);
      if (o_done) begin
        got = 1'b1;
        done_c = cyc;
        checks++;
        if (o_busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_done: got %b want 0", o_busy);
        end
      end
    end
    i_arm = 1'b0;
    i_stop = 1'b0;
    model_run(a, p, b, s);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: no o_done within %0d cycles", n);
    end
    ok = (q_tick.size() == e_tick.size());
    if (ok) foreach (q_tick[i]) if (q_tick[i] != e_tick[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tick_list P=%0d B=%0d: got %0d ticks want %0d",
               p, b, q_tick.size(), e_tick.size());
    end
    ok = (q_start.size() == e_start.size());
    if (ok) foreach (q_start[i]) if (q_start[i] != e_start[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL start_list P=%0d B=%0d: got %0d starts want %0d",
               p, b, q_start.size(), e_start.size());
    end
    checks++;
    if (done_c != e_done) begin
      errors++;
      $display("FAIL done_cycle P=%0d B=%0d: got %0d want %0d",
               p, b, done_c - a, e_done - a);
    end
    checks++;
    if (o_miss_count !== MW'(e_miss)) begin
      errors++;
      $display("FAIL miss_count P=%0d B=%0d: got %0d want %0d",
               p, b, o_miss_count, e_miss);
    end
    n_start = q_start.size();
    n_tick = q_tick.size();
    first_s = (n_start > 0) ? q_start[0] : -1;
    last_s = (n_start > 0) ? q_start[n_start-1] : -1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if ({o_drv_start, o_tick, o_busy, o_done} !== 4'b0 ||
        o_miss_count !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b%b%b%b miss %0d want 0",
               o_drv_start, o_tick, o_busy, o_done, o_miss_count);
    end
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy %b want 0", o_busy);
    end
  endtask

  task automatic test_continuous();
    int a, ns, nt, fs, ls;
    run_case(24, 0, 140, 1'b0, a, ns, nt, fs, ls);
    checks++;
    if (fs != a + 2) begin
      errors++;
      $display("FAIL cont_first_start: got +%0d want +2", fs - a);
    end
    checks++;
    if (ns != 6 || ls - fs != 125) begin
      errors++;
      $display("FAIL cont_spacing: got %0d starts span %0d want 6/125",
               ns, ls - fs);
    end
  endtask

  task automatic test_burst();
    int a, ns, nt, fs, ls;
    run_case(24, 3, 0, 1'b0, a, ns, nt, fs, ls);
    checks++;
    if (ns != 3) begin
      errors++;
      $display("FAIL burst_starts: got %0d want 3", ns);
    end
  endtask

  task automatic test_overrun();
    int a, ns, nt, fs, ls;
    run_case(17, 4, 0, 1'b0, a, ns, nt, fs, ls);
    checks++;
    if (ns != 4 || nt != 7 || o_miss_count !== 8'd3) begin
      errors++;
      $display("FAIL overrun: starts %0d ticks %0d miss %0d want 4/7/3",
               ns, nt, o_miss_count);
    end
  endtask

  task automatic test_saturation();
    int starts;
    int r;
    int done_c;
    bit early;
    hold_mask = 2'b10;
    starts = 0;
    @(posedge i_clk); #1;
    i_period = '0;
    i_burst_len = '0;
    i_arm = 1'b1;
    repeat (300) begin
      @(posedge i_clk); #1;
      i_arm = 1'b0;
      if (o_drv_start) starts++;
    end
    i_stop = 1'b1;
    @(posedge i_clk); #1;
    i_stop = 1'b0;
    checks++;
    if (o_miss_count !== 8'd255 || starts != 0) begin
      errors++;
      $display("FAIL sat_count: miss %0d starts %0d want 255/0",
               o_miss_count, starts);
    end
    early = 1'b0;
    repeat (20) begin
      @(posedge i_clk); #1;
      if (o_done || !o_busy) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL sat_drain_hold: got early exit want held");
    end
    hold_mask = 2'b00;
    r = cyc;
    done_c = -1;
    for (int k = 0; k < 10 && done_c < 0; k++) begin
      @(posedge i_clk); #1;
      if (o_done) done_c = cyc;
    end
    checks++;
    if (done_c != r + 1) begin
      errors++;
      $display("FAIL sat_release_done: got %0d want %0d", done_c - r, 1);
    end
    @(posedge i_clk); #1;
    i_period = PW'(24);
    i_burst_len = BW'(1);
    i_arm = 1'b1;
    @(posedge i_clk); #1;
    i_arm = 1'b0;
    checks++;
    if (o_miss_count !== 8'd0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL sat_rearm_clear: miss %0d busy %b want 0/1",
               o_miss_count, o_busy);
    end
    done_c = -1;
    for (int k = 0; k < 100 && done_c < 0; k++) begin
      @(posedge i_clk); #1;
      if (o_done) done_c = cyc;
    end
    checks++;
    if (done_c < 0) begin
      errors++;
      $display("FAIL sat_rearm_done: got none want done");
    end
  endtask

  task automatic test_stop_collision();
    int a, ns, nt, fs, ls;
    run_case(24, 0, 76, 1'b1, a, ns, nt, fs, ls);
    checks++;
    if (ns != 3 || o_miss_count !== 8'd0) begin
      errors++;
      $display("FAIL stop_collide: starts %0d miss %0d want 3/0",
               ns, o_miss_count);
    end
  endtask

  task automatic test_reset_mid();
    int a, ns, nt, fs, ls;
    @(posedge i_clk); #1;
    i_period = PW'(24);
    i_burst_len = '0;
    i_arm = 1'b1;
    a = cyc;
    @(posedge i_clk); #1;
    i_arm = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if (o_drv_start !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_start: got %b want 1", o_drv_start);
    end
    repeat (5) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_drv_start, o_tick, o_busy, o_done} !== 4'b0 ||
        o_miss_count !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b%b%b%b want 0",
               o_drv_start, o_tick, o_busy, o_done);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    run_case(24, 0, 100, 1'b0, a, ns, nt, fs, ls);
    checks++;
    if (fs != a + 2) begin
      errors++;
      $display("FAIL rst_rearm_first: got +%0d want +2", fs - a);
    end
  endtask

  task automatic test_random();
    int a, ns, nt, fs, ls;
    int p, b, st;
    bit am;
    for (int k = 0; k < 10; k++) begin
      p = int'($urandom_range(0, 40));
      am = bit'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        b = 0;
        st = int'($urandom_range(3, 150));
      end else begin
        b = int'($urandom_range(1, 5));
        st = 0;
      end
      run_case(p, b, st, am, a, ns, nt, fs, ls);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_burst();
    test_overrun();
    test_saturation();
    test_stop_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
